// File: rtl/djs130_int_arb_if.sv
// Bus bundle for the djs130 interrupt arbiter.
// Carries the device request lines, the CPU-side control strobes (ION, IORST,
// MSKO, INTA) and the arbiter's responses (INT REQ, INTA code strobe,
// pending vector, busy).
//   slave  : arbiter side (requests/strobes in, responses out)
//   master : CPU / device side (drives requests/strobes, reads responses)
interface djs130_int_arb_if #(
  parameter int NDEV = 9
);
  logic [NDEV-1:0] i_dev_ZDQQ;
  logic            i_int_en;
  logic            i_iorst;
  logic            i_msk_we;
  logic [15:0]     i_msk_data;
  logic            i_inta;
  logic            o_int_req;
  logic            o_inta_valid;
  logic [5:0]      o_inta_code;
  logic [NDEV-1:0] o_pend;
  logic            o_busy;

  modport slave (
    input  i_dev_ZDQQ, i_int_en, i_iorst, i_msk_we, i_msk_data, i_inta,
    output o_int_req, o_inta_valid, o_inta_code, o_pend, o_busy
  );

  modport master (
    output i_dev_ZDQQ, i_int_en, i_iorst, i_msk_we, i_msk_data, i_inta,
    input  o_int_req, o_inta_valid, o_inta_code, o_pend, o_busy
  );
endinterface

// File: rtl/djs130_int_arb.sv
// djs130 interrupt arbiter.
// Registers level requests, applies the interrupt mask, raises INT REQ to the
// CPU and answers INTA with the code of the lowest-numbered unmasked device.
// After an acknowledge, INT REQ stays suppressed for DEFER cycles.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : djs130_int_arb_if.slave (requests, strobes, responses)
// Parameters:
//   DEV_BASE : device code of request bit 0
//   NDEV     : number of request inputs
//   DEFER    : INT REQ hold-off cycles after an acknowledge
module djs130_int_arb #(
  parameter int DEV_BASE = 7,
  parameter int NDEV     = 9,
  parameter int DEFER    = 4
) (
  input logic            clk,
  input logic            rst_n,
  djs130_int_arb_if.slave bus
);

  localparam int CW = (DEFER > 1) ? $clog2(DEFER + 1) : 1;

  typedef enum logic [1:0] {S_IDLE, S_LATCH, S_ACK, S_DEFER} state_t;

  state_t          state, nxt;
  logic [NDEV-1:0] r_req, mask, pend_q, eff;
  logic [CW-1:0]   cnt, cnt_d;
  logic [5:0]      code_cap, code_cap_d, code_q, code_d;
  logic [5:0]      lo_code;
  logic            int_req_q, int_req_d;
  logic            valid_q, valid_d;

  // Only the low NDEV mask bits are meaningful; the rest are dropped.
  logic unused_msk;
  assign unused_msk = ^bus.i_msk_data;

  assign eff = r_req & ~mask;

  // Lowest set index wins: scan downward so the last hit is the lowest.
  always_comb begin
    lo_code = '0;
    for (int k = NDEV - 1; k >= 0; k--)
      if (eff[k]) lo_code = 6'(DEV_BASE + k);
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= nxt;
  end

  // Next-state logic; IORST forces IDLE regardless of the current state.
  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE:  if (bus.i_inta) nxt = S_LATCH;
      S_LATCH: nxt = S_ACK;
      S_ACK:   nxt = (DEFER == 0) ? S_IDLE : S_DEFER;
      S_DEFER: if (cnt <= CW'(1)) nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
    if (bus.i_iorst) nxt = S_IDLE;
  end

  // Output / datapath next values.
  // INT REQ looks at the registered pending vector, so it trails o_pend by one
  // edge. The LATCH code uses the live eff so a mask load on the INTA edge, or a
  // request dropping before LATCH, is reflected in the code.
  always_comb begin
    int_req_d  = bus.i_int_en & (|pend_q) & (state == S_IDLE) & ~bus.i_inta;
    valid_d    = (state == S_ACK);
    code_cap_d = (state == S_LATCH) ? lo_code : code_cap;
    code_d     = (state == S_ACK) ? code_cap : code_q;
    cnt_d      = cnt;
    if (state == S_ACK)                      cnt_d = CW'(DEFER);
    else if (state == S_DEFER && cnt != '0)  cnt_d = cnt - CW'(1);
    if (bus.i_iorst) begin
      int_req_d = 1'b0;
      valid_d   = 1'b0;
      cnt_d     = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_req     <= '0;
      mask      <= '0;
      pend_q    <= '0;
      cnt       <= '0;
      code_cap  <= '0;
      code_q    <= '0;
      int_req_q <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      r_req     <= bus.i_dev_ZDQQ;
      pend_q    <= eff;
      cnt       <= cnt_d;
      code_cap  <= code_cap_d;
      code_q    <= code_d;
      int_req_q <= int_req_d;
      valid_q   <= valid_d;
      if (bus.i_iorst)       mask <= '0;
      else if (bus.i_msk_we) mask <= bus.i_msk_data[NDEV-1:0];
    end
  end

  assign bus.o_int_req    = int_req_q;
  assign bus.o_inta_valid = valid_q;
  assign bus.o_inta_code  = code_q;
  assign bus.o_pend       = pend_q;
  assign bus.o_busy       = (state != S_IDLE);

endmodule

// File: tb/tb_djs130_int_arb.sv
module tb_djs130_int_arb;
  localparam int NDEV = 9;
  localparam int DEFER = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   exp_q[$];

  djs130_int_arb_if #(.NDEV(NDEV)) bus ();

  djs130_int_arb #(.DEV_BASE(7), .NDEV(NDEV), .DEFER(DEFER)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  always #5 clk = ~clk;

  // Advance n rising edges, then settle 1 time unit past the edge.
  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.i_dev_ZDQQ = '1; bus.i_int_en = 1'b1; bus.i_iorst = 1'b0;
    bus.i_msk_we = 1'b0; bus.i_msk_data = '0; bus.i_inta = 1'b0;
    rst_n = 1'b0;
    step(3);
    total++; if (bus.o_int_req !== 1'b0) begin bad++; $display("FAIL rst_int_req got=%b want=0", bus.o_int_req); end
    total++; if (bus.o_inta_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b want=0", bus.o_inta_valid); end
    total++; if (bus.o_inta_code !== 6'd0) begin bad++; $display("FAIL rst_code got=%0d want=0", bus.o_inta_code); end
    total++; if (bus.o_pend !== 9'd0) begin bad++; $display("FAIL rst_pend got=%h want=0", bus.o_pend); end
    total++; if (bus.o_busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", bus.o_busy); end
    bus.i_dev_ZDQQ = '0;
    rst_n = 1'b1;
    step(2);
  endtask

  task automatic test_pend();
    bus.i_dev_ZDQQ = 9'b000100000;
    step(1);
    total++; if (bus.o_pend !== 9'd0) begin bad++; $display("FAIL pend_edge1 got=%h want=0", bus.o_pend); end
    step(1);
    total++; if (bus.o_pend !== 9'b000100000) begin bad++; $display("FAIL pend_edge2 got=%h want=020", bus.o_pend); end
    total++; if (bus.o_int_req !== 1'b0) begin bad++; $display("FAIL int_req_edge2 got=%b want=0", bus.o_int_req); end
    step(1);
    total++; if (bus.o_int_req !== 1'b1) begin bad++; $display("FAIL int_req_edge3 got=%b want=1", bus.o_int_req); end
  endtask

  // Devices 9 and 14: lowest wins, INT REQ held low for DEFER+3 cycles.
  task automatic test_ack();
    int seen = 0;
    bus.i_dev_ZDQQ = 9'b010000100;
    step(3);
    total++; if (bus.o_int_req !== 1'b1) begin bad++; $display("FAIL ack_pre_int_req got=%b want=1", bus.o_int_req); end
    exp_q.push_back(9);
    bus.i_inta = 1'b1;
    step(1);
    bus.i_inta = 1'b0;
    for (int i = 0; i < DEFER + 3; i++) begin
      total++; if (bus.o_int_req !== 1'b0) begin bad++; $display("FAIL ack_int_req_low cyc=%0d got=%b want=0", i, bus.o_int_req); end
      if (bus.o_inta_valid === 1'b1) begin
        seen++;
        total++; if (i != 2) begin bad++; $display("FAIL ack_latency got=%0d want=2", i); end
        total++;
        if (exp_q.size() == 0) begin bad++; $display("FAIL ack_unexpected_valid got=%0d want=none", bus.o_inta_code); end
        else begin
          int e = exp_q.pop_front();
          if (bus.o_inta_code !== 6'(e)) begin bad++; $display("FAIL ack_code got=%0d want=%0d", bus.o_inta_code, e); end
        end
      end
      step(1);
    end
    total++; if (seen != 1) begin bad++; $display("FAIL ack_valid_count got=%0d want=1", seen); end
    total++; if (bus.o_int_req !== 1'b1) begin bad++; $display("FAIL ack_int_req_back got=%b want=1", bus.o_int_req); end
  endtask

  // Mask load on the INTA edge governs the code (dev 9 masked -> 14).
  task automatic test_mask_same_edge();
    int seen = 0;
    bus.i_dev_ZDQQ = 9'b010000100;
    exp_q.push_back(14);
    bus.i_msk_we = 1'b1; bus.i_msk_data = 16'h0004; bus.i_inta = 1'b1;
    step(1);
    bus.i_msk_we = 1'b0; bus.i_inta = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (bus.o_inta_valid === 1'b1) begin
        seen++;
        total++;
        if (exp_q.size() == 0) begin bad++; $display("FAIL msk_unexpected_valid got=%0d want=none", bus.o_inta_code); end
        else begin
          int e = exp_q.pop_front();
          if (bus.o_inta_code !== 6'(e)) begin bad++; $display("FAIL msk_code got=%0d want=%0d", bus.o_inta_code, e); end
        end
      end
      step(1);
    end
    total++; if (seen != 1) begin bad++; $display("FAIL msk_valid_count got=%0d want=1", seen); end
    bus.i_msk_we = 1'b1; bus.i_msk_data = 16'h0000;
    step(1);
    bus.i_msk_we = 1'b0;
  endtask

  // Dev 9 drops on the INTA edge: excluded, code comes from dev 14.
  task automatic test_drop();
    int seen = 0;
    bus.i_dev_ZDQQ = 9'b010000100;
    step(3);
    exp_q.push_back(14);
    bus.i_dev_ZDQQ = 9'b010000000; bus.i_inta = 1'b1;
    step(1);
    bus.i_inta = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (bus.o_inta_valid === 1'b1) begin
        seen++;
        total++;
        if (exp_q.size() == 0) begin bad++; $display("FAIL drop_unexpected_valid got=%0d want=none", bus.o_inta_code); end
        else begin
          int e = exp_q.pop_front();
          if (bus.o_inta_code !== 6'(e)) begin bad++; $display("FAIL drop_code got=%0d want=%0d", bus.o_inta_code, e); end
        end
      end
      step(1);
    end
    total++; if (seen != 1) begin bad++; $display("FAIL drop_valid_count got=%0d want=1", seen); end
  endtask

  // No requests: code 0, INTA repeated during DEFER ignored, int_en=0.
  task automatic test_no_req();
    int seen = 0;
    bus.i_dev_ZDQQ = '0; bus.i_int_en = 1'b0;
    step(3);
    exp_q.push_back(0);
    bus.i_inta = 1'b1;
    step(1);
    bus.i_inta = 1'b0;
    for (int i = 0; i < 12; i++) begin
      bus.i_inta = (i == 3);
      if (bus.o_inta_valid === 1'b1) begin
        seen++;
        total++;
        if (exp_q.size() == 0) begin bad++; $display("FAIL noreq_unexpected_valid got=%0d want=none", bus.o_inta_code); end
        else begin
          int e = exp_q.pop_front();
          if (bus.o_inta_code !== 6'(e)) begin bad++; $display("FAIL noreq_code got=%0d want=%0d", bus.o_inta_code, e); end
        end
      end
      step(1);
    end
    bus.i_inta = 1'b0;
    total++; if (seen != 1) begin bad++; $display("FAIL noreq_valid_count got=%0d want=1", seen); end
    total++; if (bus.o_inta_code !== 6'd0) begin bad++; $display("FAIL noreq_code_hold got=%0d want=0", bus.o_inta_code); end
    bus.i_int_en = 1'b1;
  endtask

  // Full mask blocks everything; IORST clears it and beats MSKO/INTA.
  task automatic test_iorst();
    int seen = 0;
    bus.i_dev_ZDQQ = '1;
    bus.i_msk_we = 1'b1; bus.i_msk_data = 16'h01FF;
    step(1);
    bus.i_msk_we = 1'b0;
    step(3);
    total++; if (bus.o_pend !== 9'd0) begin bad++; $display("FAIL iorst_masked_pend got=%h want=0", bus.o_pend); end
    total++; if (bus.o_int_req !== 1'b0) begin bad++; $display("FAIL iorst_masked_int_req got=%b want=0", bus.o_int_req); end
    bus.i_iorst = 1'b1; bus.i_msk_we = 1'b1; bus.i_inta = 1'b1;
    step(1);
    bus.i_iorst = 1'b0; bus.i_msk_we = 1'b0; bus.i_inta = 1'b0;
    total++; if (bus.o_busy !== 1'b0) begin bad++; $display("FAIL iorst_busy got=%b want=0", bus.o_busy); end
    total++; if (bus.o_int_req !== 1'b0) begin bad++; $display("FAIL iorst_int_req_e0 got=%b want=0", bus.o_int_req); end
    if (bus.o_inta_valid === 1'b1) seen++;
    step(1);
    total++; if (bus.o_pend !== 9'h1FF) begin bad++; $display("FAIL iorst_pend got=%h want=1ff", bus.o_pend); end
    total++; if (bus.o_int_req !== 1'b0) begin bad++; $display("FAIL iorst_int_req_e1 got=%b want=0", bus.o_int_req); end
    if (bus.o_inta_valid === 1'b1) seen++;
    step(1);
    total++; if (bus.o_int_req !== 1'b1) begin bad++; $display("FAIL iorst_int_req_e2 got=%b want=1", bus.o_int_req); end
    for (int i = 0; i < 5; i++) begin
      if (bus.o_inta_valid === 1'b1) seen++;
      step(1);
    end
    total++; if (seen != 0) begin bad++; $display("FAIL iorst_inta_override got=%0d want=0", seen); end
  endtask

  // Reset asserted in ACK: outputs drop at once, no strobe afterwards.
  task automatic test_reset_mid();
    int seen = 0;
    bus.i_dev_ZDQQ = 9'b000000010;
    step(3);
    bus.i_inta = 1'b1;
    step(1);
    bus.i_inta = 1'b0;
    step(1);
    total++; if (bus.o_busy !== 1'b1) begin bad++; $display("FAIL mid_busy_before got=%b want=1", bus.o_busy); end
    rst_n = 1'b0;
    #1;
    total++; if ({bus.o_int_req, bus.o_inta_valid, bus.o_busy} !== 3'b000) begin bad++; $display("FAIL mid_ctrl got=%b want=000", {bus.o_int_req, bus.o_inta_valid, bus.o_busy}); end
    total++; if ({bus.o_inta_code, bus.o_pend} !== 15'd0) begin bad++; $display("FAIL mid_data got=%h want=0", {bus.o_inta_code, bus.o_pend}); end
    step(2);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (bus.o_inta_valid === 1'b1) seen++;
      step(1);
    end
    total++; if (seen != 0) begin bad++; $display("FAIL mid_no_valid got=%0d want=0", seen); end
    total++; if (bus.o_busy !== 1'b0) begin bad++; $display("FAIL mid_idle got=%b want=0", bus.o_busy); end
  endtask

  initial begin
    test_reset();
    test_pend();
    test_ack();
    test_mask_same_edge();
    test_drop();
    test_no_req();
    test_iorst();
    test_reset_mid();
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL scoreboard_leftover got=%0d want=0", exp_q.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
